// File: rtl/cordic_pkg.sv
// Shared constants for the cordic result collector: word format and cordic mode encodings.
package cordic_pkg;

  localparam int unsigned WORD_LENGTH     = 32;
  localparam int unsigned FRACTION_LENGTH = 22;

  localparam logic [1:0] MODE_VECTOR = 2'b00;
  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_XFORM  = 2'b10;

endpackage

// File: rtl/cordic_result_collector_if.sv
// Request, cordic-core and result signals of the collector.
// The collector is the slave; the system side and the cordic core form the master.
interface cordic_result_collector_if #(
  parameter int unsigned WL    = cordic_pkg::WORD_LENGTH,
  parameter int unsigned SEQ_W = 4
);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_mode;
  logic [WL-1:0]    req_x;
  logic [WL-1:0]    req_y;
  logic [WL-1:0]    req_theta;

  logic [1:0]       cordic_mode;
  logic [WL-1:0]    cordic_x;
  logic [WL-1:0]    cordic_y;
  logic [WL-1:0]    cordic_theta;
  logic [WL-1:0]    cordic_out1;
  logic [WL-1:0]    cordic_out2;

  logic             res_valid;
  logic             res_ready;
  logic [1:0]       res_mode;
  logic [SEQ_W-1:0] res_seq;
  logic [WL-1:0]    res_out1;
  logic [WL-1:0]    res_out2;
  logic             overflow;

  modport slave (
    input  req_valid, req_mode, req_x, req_y, req_theta,
    input  cordic_out1, cordic_out2,
    input  res_ready,
    output req_ready,
    output cordic_mode, cordic_x, cordic_y, cordic_theta,
    output res_valid, res_mode, res_seq, res_out1, res_out2, overflow
  );

  modport master (
    output req_valid, req_mode, req_x, req_y, req_theta,
    output cordic_out1, cordic_out2,
    output res_ready,
    input  req_ready,
    input  cordic_mode, cordic_x, cordic_y, cordic_theta,
    input  res_valid, res_mode, res_seq, res_out1, res_out2, overflow
  );

endinterface

// File: rtl/cordic_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count; DEPTH must be a power of 2.
module cordic_sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rd_en = pop & ~empty;
  // A pop frees the slot being written, so push while full is accepted alongside it.
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rptr_q];
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/cordic_result_collector.sv
// Credit-based front end for a fixed-latency cordic core: registers requests into the core,
// tracks tags alongside the pipeline and queues tagged results in an FWFT FIFO.
module cordic_result_collector
  import cordic_pkg::*;
#(
  parameter int unsigned LATENCY    = 15,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SEQ_W      = 4
) (
  input logic                     i_ccol_clk,
  input logic                     i_ccol_rst,
  cordic_result_collector_if.slave bus
);

  localparam int unsigned WL   = WORD_LENGTH;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntW = 2 + SEQ_W + 2 * WL;

  logic             accept, capture;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]  in_flight_q, fifo_count;
  logic [CntW:0]    credit_used;
  logic [SEQ_W-1:0] seq_q;
  logic             overflow_q;
  logic [LATENCY:0] dl_valid_q;
  logic [1:0]       dl_mode_q [LATENCY+1];
  logic [SEQ_W-1:0] dl_seq_q  [LATENCY+1];
  logic [EntW-1:0]  fifo_wdata, fifo_rdata;

  // Every in-flight request owns a FIFO slot, so a capture can always be stored.
  assign credit_used   = {1'b0, in_flight_q} + {1'b0, fifo_count};
  assign bus.req_ready = (credit_used < (CntW + 1)'(FIFO_DEPTH));
  assign accept        = bus.req_valid & bus.req_ready;
  assign capture       = dl_valid_q[LATENCY];

  always_ff @(posedge i_ccol_clk) begin
    if (i_ccol_rst) begin
      bus.cordic_mode  <= '0;
      bus.cordic_x     <= '0;
      bus.cordic_y     <= '0;
      bus.cordic_theta <= '0;
      seq_q            <= '0;
      in_flight_q      <= '0;
      dl_valid_q       <= '0;
      overflow_q       <= 1'b0;
    end else begin
      if (accept) begin
        bus.cordic_mode  <= bus.req_mode;
        bus.cordic_x     <= bus.req_x;
        bus.cordic_y     <= bus.req_y;
        bus.cordic_theta <= bus.req_theta;
        seq_q            <= seq_q + 1'b1;
      end
      dl_valid_q <= {dl_valid_q[LATENCY-1:0], accept};
      if (accept & ~capture) begin
        in_flight_q <= in_flight_q + 1'b1;
      end else if (~accept & capture) begin
        in_flight_q <= in_flight_q - 1'b1;
      end
      if (capture & fifo_full & ~fifo_pop) overflow_q <= 1'b1;
    end
  end

  // Tag payload needs no reset: it is qualified by dl_valid_q.
  always_ff @(posedge i_ccol_clk) begin
    dl_mode_q[0] <= bus.req_mode;
    dl_seq_q[0]  <= seq_q;
    for (int i = 1; i < LATENCY + 1; i++) begin
      dl_mode_q[i] <= dl_mode_q[i-1];
      dl_seq_q[i]  <= dl_seq_q[i-1];
    end
  end

  assign fifo_wdata = {dl_mode_q[LATENCY], dl_seq_q[LATENCY], bus.cordic_out1, bus.cordic_out2};
  assign fifo_pop   = bus.res_ready & ~fifo_empty;

  cordic_sync_fifo #(
    .WIDTH (EntW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_ccol_clk),
    .rst   (i_ccol_rst),
    .push  (capture),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.res_valid = ~fifo_empty;
  assign {bus.res_mode, bus.res_seq, bus.res_out1, bus.res_out2} = fifo_rdata;
  assign bus.overflow  = overflow_q;

endmodule
